sha256_padder: RTL
==================

// Module: sha256_padder
// PURPOSE
//  Upstream stage of the SHA-256 core. Accepts a message as a stream of 32-bit
//  big-endian words and emits FIPS 180-4 padded 512-bit blocks. Padding is the
//  0x80 byte, zero fill, and a 64-bit bit-length. Blocks leave over a
//  valid/ready handshake; the consumer loads each block into the core message
//  port and pulses start. oFirst/oLast mark the message boundaries.
// PARAMETERS
//  none. Block width is fixed at 512 bits and length width at 64 bits.
// PORTS
//  iClk         in   1    clock; all logic on posedge
//  iReset_n     in   1    reset; synchronous, active-low
//  iStart       in   1    begin a new message; sampled only in IDLE
//  iValid       in   1    iData holds a message word
//  oReady       out  1    padder can accept a word this cycle
//  iData        in   32   message word; first byte in [31:24]
//  iLast        in   1    this word is the final message word
//  iBytes       in   3    valid bytes in the final word, 0..4; values >4 act
//                         as 4; ignored (treated as 4) when iLast=0
//  oBlockValid  out  1    oBlock holds a complete block
//  iBlockReady  in   1    consumer takes oBlock this cycle
//  oBlock       out  512  block; word 0 (first in message order) in [511:480]
//  oFirst       out  1    oBlock is the first block of the message
//  oLast        out  1    oBlock is the final block of the message
//  oBusy        out  1    high from iStart acceptance until the last block is taken
// BEHAVIOUR
//  Reset (iReset_n=0 at a posedge)
//   - all outputs go to 0; state goes to IDLE; word index and bit counter clear.
//   - reset mid-message discards all partial data and any pending block.
//  Handshakes
//   - Word transfer: iValid & oReady.
//   - Block transfer: oBlockValid & iBlockReady.
//   - oReady = (state==LOAD) & ~oBlockValid. There is a single output buffer and
//     no input skid.
//   - While oBlockValid=1, oBlock/oFirst/oLast are held stable until taken.
//  States
//   - IDLE: oReady=0. iStart=1 moves to LOAD, sets oBusy, clears word index
//     w (0..15) and the 64-bit bit count L, and arms the first-block flag.
//   - LOAD, non-last word:
//     - store the word at index w, L+=32, w++.
//     - at w==15, register a full block with oLast=0 and oBlockValid=1 the next
//       cycle, then w=0.
//   - LOAD, last word: n=min(iBytes,4), L+=8*n, b=4*w+n = message bytes in this
//     block.
//     - bytes beyond n are zeroed; 0x80 goes at byte position b (if b<64);
//       remaining bytes are zero.
//     - b<=55: words 14..15 = L (final value); oLast=1; go to DRAIN.
//     - 56<=b<=63: block emitted with oLast=0; then EXTRA (no leading 0x80).
//     - b==64: block emitted with oLast=0; then EXTRA (leading 0x80 pending).
//   - EXTRA: after the previous block is taken, the next cycle presents a block
//     with:
//     - word0 = 0x80000000 if the 0x80 is pending, else 0;
//     - zeros;
//     - words 14..15 = L;
//     - oLast=1. Then go to DRAIN.
//   - DRAIN: when the oLast block is taken, go to IDLE and clear oBusy in the
//     same edge.
//  Timing and flags
//   - A block is registered on the edge of the completing word handshake, so
//     oBlockValid rises 1 cycle later.
//   - oFirst=1 only on the first block of each message.
//   - The empty message (iLast with iBytes=0 at w=0) gives one block with
//     oFirst=oLast=1.
//   - L wraps modulo 2^64; it is not checked.
//   - iStart outside IDLE is ignored.
//   - iValid while oReady=0 is ignored; the producer holds the word.
// TESTING
//  1. "abc": iStart; one word 0x61626300, iBytes=3, iLast -> one block:
//     w0=0x61626380, w1..w14=0, w15=0x00000018, oFirst=oLast=1.
//  2. Empty: iStart; word 0, iBytes=0, iLast -> w0=0x80000000, w1..w15=0,
//     oFirst=oLast=1.
//  3. 56 bytes (14 words, last iBytes=4) -> two blocks:
//     - block 1: w14=0x80000000, w15=0, oLast=0.
//     - block 2: all zero except w15=0x000001C0, oLast=1, oFirst=0.
//  4. 64 bytes (16 words) -> two blocks:
//     - block 1: raw data, oFirst=1.
//     - block 2: w0=0x80000000, w15=0x00000200, oLast=1.
//  5. Backpressure: hold iBlockReady=0 for 10 cycles after oBlockValid ->
//     oReady stays 0, oBlock unchanged, no word lost after release.
//  6. Reset mid-message: assert iReset_n=0 for 1 cycle after 7 words -> all
//     outputs 0, state IDLE; a new "abc" message then yields test 1 result.

Source files
------------

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_padder
//  Description : SHA-256 message padder. Collects a stream of 32-bit
//                big-endian message words and emits FIPS 180-4 padded
//                512-bit blocks (0x80 marker, zero fill, 64-bit bit length)
//                over a valid/ready handshake.
//  Ports       : iClk/iReset_n      clock, synchronous active-low reset
//                iStart             begin a message (sampled in IDLE only)
//                iValid/oReady      word handshake; iData, iLast, iBytes
//                oBlockValid/iBlockReady  block handshake; oBlock
//                oFirst/oLast       message boundary flags for oBlock
//                oBusy              message in progress
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_padder (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iStart,
    input  logic         iValid,
    output logic         oReady,
    input  logic [31:0]  iData,
    input  logic         iLast,
    input  logic [2:0]   iBytes,
    output logic         oBlockValid,
    input  logic         iBlockReady,
    output logic [511:0] oBlock,
    output logic         oFirst,
    output logic         oLast,
    output logic         oBusy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_EXTRA = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]   r_state;
    logic [3:0]   r_w;          // word index inside the current block
    logic [63:0]  r_len;        // message length in bits so far
    logic         r_first_pend; // next registered block is the message's first
    logic         r_pad_pend;   // 0x80 marker still owed to the extra block
    logic [511:0] r_block;
    logic         r_bvalid;
    logic         r_first;
    logic         r_last;
    logic         r_busy;

    logic         w_take;
    logic         w_accept;
    logic [2:0]   w_n;
    logic [6:0]   w_b;
    logic [31:0]  w_mask;
    logic [63:0]  w_len_nl;
    logic [63:0]  w_len_last;
    logic [511:0] w_blk_nl;
    logic [511:0] w_blk_last;
    logic [511:0] w_blk_extra;

    assign oReady      = (r_state == c_LOAD) & ~r_bvalid;
    assign oBlockValid = r_bvalid;
    assign oBlock      = r_block;
    assign oFirst      = r_first;
    assign oLast       = r_last;
    assign oBusy       = r_busy;

    assign w_take   = r_bvalid & iBlockReady;
    assign w_accept = iValid & oReady;

    // Valid bytes in the incoming word: only a final word may be short.
    assign w_n = (iLast && (iBytes <= 3'd4)) ? iBytes : 3'd4;
    // Message bytes that end up in the block this word completes.
    assign w_b = {1'b0, r_w, 2'b00} + {4'b0000, w_n};

    assign w_len_nl   = r_len + 64'd32;
    assign w_len_last = r_len + {58'd0, w_n, 3'b000};

    always_comb begin
        w_mask = 32'h0000_0000;
        case (w_n)
            3'd1:    w_mask = 32'hFF00_0000;
            3'd2:    w_mask = 32'hFFFF_0000;
            3'd3:    w_mask = 32'hFFFF_FF00;
            3'd4:    w_mask = 32'hFFFF_FFFF;
            default: w_mask = 32'h0000_0000;
        endcase
    end

    // The output register doubles as the accumulation buffer: words already
    // written at indices below r_w belong to the current block. A final word
    // rebuilds the whole block so stale words from an earlier block vanish.
    always_comb begin
        w_blk_nl   = r_block;
        w_blk_last = '0;
        for (int k = 0; k < 16; k++) begin
            if (4'(k) == r_w) begin
                w_blk_nl[511 - 32*k -: 32]   = iData;
                w_blk_last[511 - 32*k -: 32] = iData & w_mask;
            end else if (4'(k) < r_w) begin
                w_blk_last[511 - 32*k -: 32] = r_block[511 - 32*k -: 32];
            end
        end
        // Marker byte lands right after the data; with a full final word it
        // falls at byte 0 of the next word (or into the extra block at b==64).
        for (int p = 0; p < 64; p++) begin
            if (7'(p) == w_b) begin
                w_blk_last[511 - 8*p -: 8] = 8'h80;
            end
        end
        if (w_b <= 7'd55) begin
            w_blk_last[63:0] = w_len_last;
        end
    end

    assign w_blk_extra = {(r_pad_pend ? 32'h8000_0000 : 32'h0000_0000), 416'd0, r_len};

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            r_state      <= c_IDLE;
            r_w          <= 4'd0;
            r_len        <= 64'd0;
            r_first_pend <= 1'b0;
            r_pad_pend   <= 1'b0;
            r_block      <= '0;
            r_bvalid     <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (iStart) begin
                        r_state      <= c_LOAD;
                        r_busy       <= 1'b1;
                        r_w          <= 4'd0;
                        r_len        <= 64'd0;
                        r_first_pend <= 1'b1;
                        r_pad_pend   <= 1'b0;
                    end
                end
                c_LOAD: begin
                    // Take and accept are mutually exclusive: oReady needs ~r_bvalid.
                    if (w_take) begin
                        r_bvalid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (!iLast) begin
                            r_block <= w_blk_nl;
                            r_len   <= w_len_nl;
                            if (r_w == 4'd15) begin
                                r_bvalid     <= 1'b1;
                                r_first      <= r_first_pend;
                                r_first_pend <= 1'b0;
                                r_last       <= 1'b0;
                                r_w          <= 4'd0;
                            end else begin
                                r_w <= r_w + 4'd1;
                            end
                        end else begin
                            r_block      <= w_blk_last;
                            r_len        <= w_len_last;
                            r_bvalid     <= 1'b1;
                            r_first      <= r_first_pend;
                            r_first_pend <= 1'b0;
                            r_w          <= 4'd0;
                            if (w_b <= 7'd55) begin
                                r_last  <= 1'b1;
                                r_state <= c_DRAIN;
                            end else begin
                                r_last     <= 1'b0;
                                r_pad_pend <= (w_b == 7'd64);
                                r_state    <= c_EXTRA;
                            end
                        end
                    end
                end
                c_EXTRA: begin
                    // Length-only block replaces the previous one on its take edge.
                    if (w_take || !r_bvalid) begin
                        r_block  <= w_blk_extra;
                        r_bvalid <= 1'b1;
                        r_first  <= r_first_pend;
                        r_last   <= 1'b1;
                        r_state  <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_take) begin
                        r_bvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
